cavlc_enc_ctrl: RTL and testbench

Encoder-side control and bit-packing block for the CAVLC path; it mirrors the decoder control FSM. Per 4x4 block it sequences the coeff-token, level and zero encoders and muxes the active encoder's right-aligned codeword into an MSB-first 32-bit packer. The packer emits full words to the downstream bitstream writer through a valid/ready handshake. It pulses BlockDone when the block's bits have been absorbed (and flushed, if configured).

---
 rtl/cavlc_enc_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cavlc_enc_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_enc_ctrl.sv
// cavlc_enc_ctrl: CAVLC encoder control FSM and MSB-first 32-bit bit packer.
// Sequences the coeff-token, level and zero encoders for each 4x4 block.
// Only the current stage's codeword reaches the packer. Full words go out
// through a WordOut/WordValid/WordReady handshake.
// Ports: Clk, nReset (async, active-low); Enable/TotalCoeff start a block;
//   CoeffToken/Level/Zero Code, Len, Valid in; LevelEncodeDone and
//   ZeroEncodeDone in; WordReady in; CodeAccept, the three stage enables,
//   WordOut, WordValid and BlockDone out.
// Build option: CAVLC_ENC_BLOCK_FLUSH_EN adds a FLUSH state that pads and
//   emits the partial word, so every block starts word-aligned.
module cavlc_enc_ctrl #(
    parameter int MAX_COEFF = 16
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Enable,
    input  logic [4:0]  TotalCoeff,
    input  logic [15:0] CoeffTokenCode,
    input  logic [4:0]  CoeffTokenLen,
    input  logic        CoeffTokenValid,
    input  logic [15:0] LevelCode,
    input  logic [4:0]  LevelLen,
    input  logic        LevelValid,
    input  logic [15:0] ZeroCode,
    input  logic [4:0]  ZeroLen,
    input  logic        ZeroValid,
    input  logic        LevelEncodeDone,
    input  logic        ZeroEncodeDone,
    input  logic        WordReady,
    output logic        CodeAccept,
    output logic        CoeffTokenEncodeEnable,
    output logic        LevelEncodeEnable,
    output logic        ZeroEncodeEnable,
    output logic [31:0] WordOut,
    output logic        WordValid,
    output logic        BlockDone
);
    typedef enum logic [2:0] {
        WAIT_ENABLE  = 3'd0,
        COEFF_TOKEN  = 3'd1,
        LEVEL_ENCODE = 3'd2,
        ZERO_ENCODE  = 3'd3,
`ifdef CAVLC_ENC_BLOCK_FLUSH_EN
        FLUSH        = 3'd4,
`endif
        XX           = 3'd7
    } state_t;

    localparam logic [4:0] MAX_TC = 5'(MAX_COEFF);

    state_t      state, state_next;
    logic [4:0]  tc_reg;
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic [31:0] word_out;
    logic        word_valid;
    logic        block_done;

    logic        act_valid;
    logic [15:0] act_code;
    logic [4:0]  act_len;
    logic [4:0]  eff_len;
    logic [15:0] code_mask;
    logic [5:0]  sum;
    logic [5:0]  shamt;
    logic [47:0] ext;
    logic        code_accept;
    logic        stage_end;
    logic        finish;
    logic        flush_load;

    always_comb begin
        act_valid = 1'b0;
        act_code  = 16'h0;
        act_len   = 5'd0;
        case (state)
            COEFF_TOKEN: begin
                act_valid = CoeffTokenValid;
                act_code  = CoeffTokenCode;
                act_len   = CoeffTokenLen;
            end
            LEVEL_ENCODE: begin
                act_valid = LevelValid;
                act_code  = LevelCode;
                act_len   = LevelLen;
            end
            ZERO_ENCODE: begin
                act_valid = ZeroValid;
                act_code  = ZeroCode;
                act_len   = ZeroLen;
            end
            default: ;
        endcase
    end

    // Pending bits sit at the top of a 48-bit window; the new code lands
    // directly below them. Bits [47:16] are the next word or accumulator,
    // bits [15:0] are the spill-over once 32 bits are reached.
    assign eff_len     = (act_len > 5'd16) ? 5'd16 : act_len;
    assign code_mask   = 16'hFFFF >> (5'd16 - eff_len);
    assign sum         = {1'b0, cnt} + {1'b0, eff_len};
    assign shamt       = 6'd48 - sum;
    assign ext         = {acc, 16'h0}
                       | ({32'h0, act_code & code_mask} << shamt);
    assign code_accept = act_valid && (!word_valid || WordReady);

    always_comb begin
        state_next = state;
        stage_end  = 1'b0;
        finish     = 1'b0;
        flush_load = 1'b0;
        case (state)
            WAIT_ENABLE:
                if (Enable) state_next = COEFF_TOKEN;
            COEFF_TOKEN:
                if (CoeffTokenValid && code_accept) begin
                    if (tc_reg == 5'd0) stage_end = 1'b1;
                    else state_next = LEVEL_ENCODE;
                end
            LEVEL_ENCODE:
                if (LevelEncodeDone && (!LevelValid || code_accept)) begin
                    if (tc_reg >= MAX_TC) stage_end = 1'b1;
                    else state_next = ZERO_ENCODE;
                end
            ZERO_ENCODE:
                if (ZeroEncodeDone && (!ZeroValid || code_accept))
                    stage_end = 1'b1;
`ifdef CAVLC_ENC_BLOCK_FLUSH_EN
            FLUSH:
                if (cnt == 5'd0) begin
                    state_next = WAIT_ENABLE;
                    finish     = 1'b1;
                end else if (!word_valid || WordReady) begin
                    flush_load = 1'b1;
                    state_next = WAIT_ENABLE;
                    finish     = 1'b1;
                end
`endif
            default:
                state_next = WAIT_ENABLE;
        endcase
        if (stage_end) begin
`ifdef CAVLC_ENC_BLOCK_FLUSH_EN
            state_next = FLUSH;
`else
            state_next = WAIT_ENABLE;
            finish     = 1'b1;
`endif
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state      <= WAIT_ENABLE;
            tc_reg     <= 5'd0;
            block_done <= 1'b0;
        end else begin
            state      <= state_next;
            block_done <= finish;
            if (state == WAIT_ENABLE && Enable) tc_reg <= TotalCoeff;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            acc        <= 32'h0;
            cnt        <= 5'd0;
            word_out   <= 32'h0;
            word_valid <= 1'b0;
        end else begin
            // A load later in this block overrides the handshake clear.
            if (word_valid && WordReady) word_valid <= 1'b0;
            if (flush_load) begin
                word_out   <= acc;
                word_valid <= 1'b1;
                acc        <= 32'h0;
                cnt        <= 5'd0;
            end else if (code_accept) begin
                if (sum[5]) begin
                    word_out   <= ext[47:16];
                    word_valid <= 1'b1;
                    acc        <= {ext[15:0], 16'h0};
                end else begin
                    acc <= ext[47:16];
                end
                cnt <= sum[4:0];
            end
        end
    end

    assign CodeAccept             = code_accept;
    assign CoeffTokenEncodeEnable = (state == COEFF_TOKEN);
    assign LevelEncodeEnable      = (state == LEVEL_ENCODE);
    assign ZeroEncodeEnable       = (state == ZERO_ENCODE);
    assign WordOut                = word_out;
    assign WordValid              = word_valid;
    assign BlockDone              = block_done;
endmodule

// File: tb/tb_cavlc_enc_ctrl.sv
// tb_cavlc_enc_ctrl: directed bench for cavlc_enc_ctrl.
// Hand-computed packer words, FSM sequencing, stalls and reset checks.
module tb_cavlc_enc_ctrl;
`ifdef CAVLC_ENC_BLOCK_FLUSH_EN
    localparam int FL = 1;
`else
    localparam int FL = 0;
`endif

    logic        Clk = 1'b0;
    logic        nReset;
    logic        Enable;
    logic [4:0]  TotalCoeff;
    logic [15:0] CoeffTokenCode, LevelCode, ZeroCode;
    logic [4:0]  CoeffTokenLen, LevelLen, ZeroLen;
    logic        CoeffTokenValid, LevelValid, ZeroValid;
    logic        LevelEncodeDone, ZeroEncodeDone;
    logic        WordReady;
    logic        CodeAccept;
    logic        CoeffTokenEncodeEnable, LevelEncodeEnable, ZeroEncodeEnable;
    logic [31:0] WordOut;
    logic        WordValid;
    logic        BlockDone;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    cavlc_enc_ctrl dut (
        .Clk                    (Clk),
        .nReset                 (nReset),
        .Enable                 (Enable),
        .TotalCoeff             (TotalCoeff),
        .CoeffTokenCode         (CoeffTokenCode),
        .CoeffTokenLen          (CoeffTokenLen),
        .CoeffTokenValid        (CoeffTokenValid),
        .LevelCode              (LevelCode),
        .LevelLen               (LevelLen),
        .LevelValid             (LevelValid),
        .ZeroCode               (ZeroCode),
        .ZeroLen                (ZeroLen),
        .ZeroValid              (ZeroValid),
        .LevelEncodeDone        (LevelEncodeDone),
        .ZeroEncodeDone         (ZeroEncodeDone),
        .WordReady              (WordReady),
        .CodeAccept             (CodeAccept),
        .CoeffTokenEncodeEnable (CoeffTokenEncodeEnable),
        .LevelEncodeEnable      (LevelEncodeEnable),
        .ZeroEncodeEnable       (ZeroEncodeEnable),
        .WordOut                (WordOut),
        .WordValid              (WordValid),
        .BlockDone              (BlockDone)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        Enable          = 1'b0;
        TotalCoeff      = 5'd0;
        CoeffTokenCode  = 16'h0;
        CoeffTokenLen   = 5'd0;
        CoeffTokenValid = 1'b0;
        LevelCode       = 16'h0;
        LevelLen        = 5'd0;
        LevelValid      = 1'b0;
        ZeroCode        = 16'h0;
        ZeroLen         = 5'd0;
        ZeroValid       = 1'b0;
        LevelEncodeDone = 1'b0;
        ZeroEncodeDone  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wv"}, {31'h0, WordValid}, 32'h0);
        chk({tag, "_wo"}, WordOut, 32'h0);
        chk({tag, "_bd"}, {31'h0, BlockDone}, 32'h0);
        chk({tag, "_ca"}, {31'h0, CodeAccept}, 32'h0);
        chk({tag, "_en"}, {29'h0, CoeffTokenEncodeEnable,
            LevelEncodeEnable, ZeroEncodeEnable}, 32'h0);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        clear_inputs();
        CoeffTokenValid = 1'b1;
        #1;
        chk_reset_outputs("rst");
        CoeffTokenValid = 1'b0;
        tick();
        tick();
        @(negedge Clk);
        nReset = 1'b1;
        tick();
    endtask

    task automatic start_block(input logic [4:0] tc);
        Enable     = 1'b1;
        TotalCoeff = tc;
        tick();
        Enable = 1'b0;
        chk("start_cte", {31'h0, CoeffTokenEncodeEnable}, 32'h1);
    endtask

    task automatic push(input int which, input logic [15:0] code,
                        input logic [4:0] len);
        int n = 0;
        case (which)
            0: begin
                CoeffTokenCode = code; CoeffTokenLen = len;
                CoeffTokenValid = 1'b1;
            end
            1: begin
                LevelCode = code; LevelLen = len; LevelValid = 1'b1;
            end
            default: begin
                ZeroCode = code; ZeroLen = len; ZeroValid = 1'b1;
            end
        endcase
        #1;
        while (!CodeAccept && n < 20) begin
            tick();
            n++;
        end
        chk("push_wait", {31'h0, n < 20}, 32'h1);
        tick();
        CoeffTokenValid = 1'b0;
        LevelValid      = 1'b0;
        ZeroValid       = 1'b0;
    endtask

    task automatic expect_done(input string tag, input int lat);
        int n = 0;
        while (!BlockDone && n < 10) begin
            tick();
            n++;
        end
        chk(tag, n, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        nReset    = 1'b0;
        WordReady = 1'b1;
        #2;
        do_reset();

        // Block with TotalCoeff=0: one 1-bit token, stages skipped.
        start_block(5'd0);
        push(0, 16'h0001, 5'd1);
        chk("t1_le", {31'h0, LevelEncodeEnable}, 32'h0);
        expect_done("t1_done_lat", FL);
        chk("t1_bd", {31'h0, BlockDone}, 32'h1);
        chk("t1_ze", {31'h0, ZeroEncodeEnable}, 32'h0);
`ifdef CAVLC_ENC_BLOCK_FLUSH_EN
        chk("t1_flush_wv", {31'h0, WordValid}, 32'h1);
        chk("t1_flush_wo", WordOut, 32'h8000_0000);
`else
        chk("t1_wv", {31'h0, WordValid}, 32'h0);
`endif
        // Back-to-back block, Enable taken in the BlockDone cycle.
        start_block(5'd1);
        chk("t1_bd_pulse", {31'h0, BlockDone}, 32'h0);
        push(0, 16'h0000, 5'd15);
        push(1, 16'hFFFF, 5'd16);
`ifndef CAVLC_ENC_BLOCK_FLUSH_EN
        chk("t1_carry_wv", {31'h0, WordValid}, 32'h1);
        chk("t1_carry_wo", WordOut, 32'h8000_FFFF);
`endif
        LevelEncodeDone = 1'b1;
        tick();
        chk("t1_ze2", {31'h0, ZeroEncodeEnable}, 32'h1);
        LevelEncodeDone = 1'b0;
        ZeroEncodeDone  = 1'b1;
        tick();
        ZeroEncodeDone = 1'b0;
        expect_done("t1b_done_lat", FL);
`ifdef CAVLC_ENC_BLOCK_FLUSH_EN
        chk("t1b_flush_wo", WordOut, 32'h0001_FFFE);
        chk("t1b_flush_wv", {31'h0, WordValid}, 32'h1);
`endif

        // Two 16-bit pushes form one word.
        do_reset();
        start_block(5'd5);
        push(0, 16'hFFFF, 5'd16);
        chk("t2_wv0", {31'h0, WordValid}, 32'h0);
        push(1, 16'h0000, 5'd16);
        chk("t2_wv", {31'h0, WordValid}, 32'h1);
        chk("t2_wo", WordOut, 32'hFFFF_0000);
        chk("t2_le", {31'h0, LevelEncodeEnable}, 32'h1);

        // Cnt=30, then 4 bits straddle the word boundary.
        push(1, 16'h0000, 5'd16);
        chk("t3_wv_clr", {31'h0, WordValid}, 32'h0);
        push(1, 16'h0000, 5'd14);
        push(1, 16'h000B, 5'd4);
        chk("t3_wv", {31'h0, WordValid}, 32'h1);
        chk("t3_wo", WordOut, 32'h0000_0002);
        push(1, 16'h0000, 5'd16);
        push(1, 16'h0001, 5'd14);
        chk("t3_acc_wo", WordOut, 32'hC000_0001);
        tick();

        // Backpressure stalls the level stage even with Done asserted.
        WordReady = 1'b0;
        push(1, 16'hFFFF, 5'd16);
        push(1, 16'h1234, 5'd16);
        chk("t4_wo", WordOut, 32'hFFFF_1234);
        LevelCode       = 16'hABCD;
        LevelLen        = 5'd16;
        LevelValid      = 1'b1;
        LevelEncodeDone = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_ca", {31'h0, CodeAccept}, 32'h0);
            chk("t4_stall_wo", WordOut, 32'hFFFF_1234);
            chk("t4_stall_le", {31'h0, LevelEncodeEnable}, 32'h1);
            tick();
        end
        WordReady = 1'b1;
        #1;
        chk("t4_release_ca", {31'h0, CodeAccept}, 32'h1);
        tick();
        LevelValid      = 1'b0;
        LevelEncodeDone = 1'b0;
        chk("t4_ze", {31'h0, ZeroEncodeEnable}, 32'h1);
        chk("t4_wv_clr", {31'h0, WordValid}, 32'h0);
        WordReady = 1'b0;
        push(2, 16'h5555, 5'd16);
        chk("t4_wo2", WordOut, 32'hABCD_5555);
        ZeroEncodeDone = 1'b1;
        tick();
        ZeroEncodeDone = 1'b0;
        expect_done("t4_done_lat", FL);
        chk("t4_hold_wv", {31'h0, WordValid}, 32'h1);
        chk("t4_hold_wo", WordOut, 32'hABCD_5555);
        WordReady = 1'b1;
        tick();
        chk("t4_drain_wv", {31'h0, WordValid}, 32'h0);

        // TotalCoeff=16 skips the zero stage; Enable mid-block ignored.
        do_reset();
        start_block(5'd16);
        push(0, 16'h0003, 5'd2);
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        chk("t5_le", {31'h0, LevelEncodeEnable}, 32'h1);
        chk("t5_cte", {31'h0, CoeffTokenEncodeEnable}, 32'h0);
        LevelEncodeDone = 1'b1;
        tick();
        LevelEncodeDone = 1'b0;
        chk("t5_ze", {31'h0, ZeroEncodeEnable}, 32'h0);
        expect_done("t5_done_lat", FL);
        chk("t5_ze2", {31'h0, ZeroEncodeEnable}, 32'h0);
`ifdef CAVLC_ENC_BLOCK_FLUSH_EN
        chk("t5_flush_wo", WordOut, 32'hC000_0000);
`else
        chk("t5_wv", {31'h0, WordValid}, 32'h0);
`endif

        // Reset in the middle of a stalled level stage.
        do_reset();
        start_block(5'd3);
        WordReady = 1'b0;
        push(0, 16'hFFFF, 5'd16);
        push(1, 16'hFFFF, 5'd16);
        chk("t6_pre_wv", {31'h0, WordValid}, 32'h1);
        LevelValid = 1'b1;
        LevelLen   = 5'd16;
        #2;
        nReset = 1'b0;
        #1;
        chk_reset_outputs("t6_mid");
        WordReady = 1'b1;
        do_reset();
        start_block(5'd3);
        push(0, 16'h0001, 5'd16);
        push(1, 16'h0002, 5'd16);
        chk("t6_post_wo", WordOut, 32'h0001_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
